// File: rtl/hit_l1_buffer_ctrl.sv
// Address/trigger controller in front of the pixel hit L1 SRAM: circular write pointer, L1-triggered
// readback and a show-ahead output FIFO. Define HIT_L1_ERR_CNT_EN to add Hamming error counters.
module hit_l1_buffer_ctrl #(
  parameter int ADDRWIDTH = 7,
  parameter int FIFODEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dis,
  input  logic [ADDRWIDTH-1:0] latency,
  input  logic                 l1a,
  output logic                 wren,
  output logic [ADDRWIDTH-1:0] wrAddr,
  output logic                 rden,
  output logic [ADDRWIDTH-1:0] rdAddr,
  input  logic                 outHit,
  input  logic                 E1A,
  input  logic                 E2A,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_hit,
  output logic [ADDRWIDTH-1:0] out_addr,
  output logic [1:0]           out_err,
  output logic [7:0]           ovf_cnt
`ifdef HIT_L1_ERR_CNT_EN
  ,
  output logic [7:0]           e1_cnt,
  output logic [7:0]           e2_cnt
`endif
);

  localparam int PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDRWIDTH + 2;
  localparam logic [ADDRWIDTH-1:0] LAT_MIN = ADDRWIDTH'(2);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    sat_inc8 = (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  logic                 wren_q, wren_d;
  logic [ADDRWIDTH-1:0] wraddr_q, wraddr_d;
  logic                 rden_q, rden_d;
  logic [ADDRWIDTH-1:0] rdaddr_q, rdaddr_d;
  logic [ADDRWIDTH-1:0] lat_eff;
  logic                 trig;
  logic                 pend_q;
  logic [ADDRWIDTH-1:0] rdaddr_dly_q;

  logic [EW-1:0]        fifo_mem [FIFODEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           ovf_q, ovf_d;
  logic                 push, pop, full, accept, drop;
  logic [EW-1:0]        entry, head;

  // Stage 0: write pointer and trigger address generation
  always_comb begin
    wren_d   = ~dis;
    wraddr_d = wren_q ? wraddr_q + ADDRWIDTH'(1) : wraddr_q;
    lat_eff  = (latency < LAT_MIN) ? LAT_MIN : latency;
    trig     = l1a & ~dis;
    rden_d   = trig;
    // Modular subtraction handles the wrap of the circular buffer.
    rdaddr_d = trig ? wraddr_q - lat_eff : rdaddr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      rden_q   <= 1'b0;
      rdaddr_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      rden_q   <= rden_d;
      rdaddr_q <= rdaddr_d;
      pend_q   <= rden_q;
    end
  end

  // Stage 1: SRAM read in flight, address follows the data
  always_ff @(posedge clk) begin
    rdaddr_dly_q <= rdaddr_q;
  end

  // Stage 2: capture read data into the output FIFO
  always_comb begin
    entry  = {outHit, rdaddr_dly_q, E2A, E1A};
    push   = pend_q;
    pop    = (cnt_q != '0) & out_ready;
    full   = (cnt_q == CW'(FIFODEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    accept = push & (~full | pop);
    drop   = push & full & ~pop;
    wptr_d = accept ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = sat_inc8(ovf_q, drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      fifo_mem[wptr_q] <= entry;
    end
  end

`ifdef HIT_L1_ERR_CNT_EN
  logic [7:0] e1_q, e1_d, e2_q, e2_d;

  always_comb begin
    e1_d = sat_inc8(e1_q, accept & entry[0]);
    e2_d = sat_inc8(e2_q, accept & entry[1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e1_q <= '0;
      e2_q <= '0;
    end else begin
      e1_q <= e1_d;
      e2_q <= e2_d;
    end
  end

  assign e1_cnt = e1_q;
  assign e2_cnt = e2_q;
`endif

  // Head entry is masked so an empty FIFO presents zeros without resetting storage.
  assign head      = fifo_mem[rptr_q];
  assign out_valid = (cnt_q != '0);
  assign out_hit   = out_valid & head[EW-1];
  assign out_addr  = out_valid ? head[EW-2:2] : '0;
  assign out_err   = out_valid ? head[1:0] : 2'b00;
  assign ovf_cnt   = ovf_q;
  assign wren      = wren_q;
  assign wrAddr    = wraddr_q;
  assign rden      = rden_q;
  assign rdAddr    = rdaddr_q;

endmodule
